// File: rtl/hb3_pkg.sv
// Shared definitions for the HB3 ramp controller and its helpers.
package hb3_pkg;

  // FSM encoding of the ramp controller.
  typedef enum logic [1:0] {
    TRACK     = 2'd0,
    STOP_RAMP = 2'd1,
    DEAD      = 2'd2
  } state_t;

  // Width of the duty command sent to the bridge driver.
  localparam int SPEED_W = 8;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/hb3_tick_gen.sv
// Free-running prescaler producing a one-cycle strobe every STEP_DIV clocks.
module hb3_tick_gen
  import hb3_pkg::*;
#(
  parameter int STEP_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = cnt_w(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] count_reg;

  // Count 0..STEP_DIV-1 and wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/hb3_ramp_ctrl.sv
// Slew-rate limited speed/direction command for the HB3 H-bridge.
// Reversals always pass through zero speed and a dead-time hold.
module hb3_ramp_ctrl
  import hb3_pkg::*;
#(
  parameter int STEP_DIV    = 1000,
  parameter int RAMP_STEP   = 1,
  parameter int DEAD_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] target_speed,
  input  logic               target_dir,
  input  logic               stop,
  output logic [SPEED_W-1:0] speed,
  output logic               direction_control,
  output logic               busy,
  output logic               at_target
);

  localparam int DW = cnt_w(DEAD_CYCLES);
  localparam logic [DW-1:0]      DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [SPEED_W:0]   STEP9     = (SPEED_W + 1)'(RAMP_STEP);

  state_t             state_reg, state_next;
  logic [SPEED_W-1:0] speed_reg, speed_next;
  logic               dir_reg, dir_next;
  logic [DW-1:0]      dead_reg, dead_next;
  logic               estop_dead_reg, estop_dead_next;
  logic               at_target_reg;
  logic               tick;

  hb3_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // One slew step toward goal in 9-bit arithmetic; lands exactly on goal
  // when it is within one step, so there is no overshoot or wrap.
  function automatic logic [SPEED_W-1:0] step_toward(input logic [SPEED_W-1:0] cur,
                                                     input logic [SPEED_W-1:0] goal);
    logic [SPEED_W:0] cur9, goal9, diff9, res9;
    cur9  = {1'b0, cur};
    goal9 = {1'b0, goal};
    diff9 = (goal9 >= cur9) ? (goal9 - cur9) : (cur9 - goal9);
    if (diff9 <= STEP9)     res9 = goal9;
    else if (goal9 > cur9)  res9 = cur9 + STEP9;
    else                    res9 = cur9 - STEP9;
    return res9[SPEED_W-1:0];
  endfunction

  // State, speed, direction and dead-time registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= TRACK;
      speed_reg      <= '0;
      dir_reg        <= 1'b0;
      dead_reg       <= '0;
      estop_dead_reg <= 1'b0;
      at_target_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      speed_reg      <= speed_next;
      dir_reg        <= dir_next;
      dead_reg       <= dead_next;
      estop_dead_reg <= estop_dead_next;
      at_target_reg  <= (state_reg == TRACK) && (speed_reg == target_speed) &&
                        (dir_reg == target_dir);
    end
  end

  // Next-state logic; any state transition suppresses the tick step.
  // estop_dead marks a dead time entered by stop, which must run to
  // completion even if the requested direction already matches.
  always_comb begin
    state_next      = state_reg;
    speed_next      = speed_reg;
    dir_next        = dir_reg;
    dead_next       = dead_reg;
    estop_dead_next = estop_dead_reg;
    if (stop) begin
      speed_next      = '0;
      state_next      = DEAD;
      dead_next       = '0;
      estop_dead_next = 1'b1;
    end else begin
      case (state_reg)
        TRACK: begin
          if (target_dir != dir_reg) begin
            if (speed_reg != '0) begin
              state_next = STOP_RAMP;
            end else begin
              state_next = DEAD;
              dead_next  = '0;
            end
          end else if (tick) begin
            speed_next = step_toward(speed_reg, target_speed);
          end
        end
        STOP_RAMP: begin
          if (target_dir == dir_reg) begin
            state_next = TRACK;
          end else if (speed_reg == '0) begin
            state_next = DEAD;
            dead_next  = '0;
          end else if (tick) begin
            speed_next = step_toward(speed_reg, '0);
          end
        end
        DEAD: begin
          speed_next = '0;
          if (!estop_dead_reg && (target_dir == dir_reg)) begin
            state_next = TRACK;
            dead_next  = '0;
          end else if (dead_reg == DEAD_LAST) begin
            dir_next        = target_dir;
            state_next      = TRACK;
            dead_next       = '0;
            estop_dead_next = 1'b0;
          end else begin
            dead_next = dead_reg + DW'(1);
          end
        end
        default: begin
          state_next = TRACK;
          speed_next = '0;
        end
      endcase
    end
  end

  assign speed             = speed_reg;
  assign direction_control = dir_reg;
  assign busy              = (state_reg != TRACK);
  assign at_target         = at_target_reg;

endmodule

// File: tb/tb_hb3_ramp_ctrl.sv
// Scenario bench for hb3_ramp_ctrl with STEP_DIV=4, RAMP_STEP=16, DEAD_CYCLES=10.
module tb_hb3_ramp_ctrl;

  localparam int STEP_DIV    = 4;
  localparam int RAMP_STEP   = 16;
  localparam int DEAD_CYCLES = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] target_speed = 8'hFF;
  logic       target_dir = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] speed;
  logic       direction_control;
  logic       busy;
  logic       at_target;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  hb3_ramp_ctrl #(
    .STEP_DIV    (STEP_DIV),
    .RAMP_STEP   (RAMP_STEP),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .target_speed      (target_speed),
    .target_dir        (target_dir),
    .stop              (stop),
    .speed             (speed),
    .direction_control (direction_control),
    .busy              (busy),
    .at_target         (at_target)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every speed change pops the next expected value;
  // every direction change must follow at least DEAD_CYCLES zero samples.
  logic [7:0] prev_speed;
  logic       prev_dir;
  int         zero_run = 0;
  logic       rst_edge;
  logic [7:0] exp_v;
  always @(posedge clk) begin
    rst_edge = rst;
    #1;
    if (!rst_edge) begin
      if (speed !== prev_speed) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL speed_seq: unexpected speed 0x%02h (prev 0x%02h)", speed, prev_speed);
        end else begin
          exp_v = exp_q.pop_front();
          if (speed !== exp_v) begin
            n_fail++;
            $display("FAIL speed_seq: got 0x%02h expected 0x%02h", speed, exp_v);
          end else begin
            $display("step speed 0x%02h dir %0b", speed, direction_control);
          end
        end
      end
      if (direction_control !== prev_dir) begin
        n_checks++;
        if (zero_run < DEAD_CYCLES) begin
          n_fail++;
          $display("FAIL dir_flip_guard: zero samples %0d required >= %0d", zero_run, DEAD_CYCLES);
        end else begin
          $display("flip dir %0b after %0d zero samples", direction_control, zero_run);
        end
      end
    end
    zero_run   = (speed === 8'h00) ? zero_run + 1 : 0;
    prev_speed = speed;
    prev_dir   = direction_control;
  end

  task automatic wait_speed(input logic [7:0] v, input int budget, output bit ok);
    ok = (speed === v);
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = (speed === v);
    end
  endtask

  task automatic push_ramp(input int from, input int to);
    int v;
    v = from;
    if (to >= from) begin
      while (v < to) begin
        v = (to - v <= RAMP_STEP) ? to : v + RAMP_STEP;
        exp_q.push_back(8'(v));
      end
    end else begin
      while (v > to) begin
        v = (v - to <= RAMP_STEP) ? to : v - RAMP_STEP;
        exp_q.push_back(8'(v));
      end
    end
  endtask

  task automatic test_reset;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (speed !== 8'h00 || direction_control !== 1'b0 || busy !== 1'b0 || at_target !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: speed 0x%02h dir %0b busy %0b at %0b required 0/0/0/0",
                 speed, direction_control, busy, at_target);
      end else $display("reset cycle %0d ok", c);
    end
  endtask

  task automatic test_ramp_up;
    logic [7:0] last;
    int gap;
    target_speed = 8'h85;
    push_ramp(0, 8'h85);
    rst = 1'b0;
    last = 8'h00;
    gap = 0;
    for (int c = 0; c < 200 && speed !== 8'h85; c++) begin
      @(negedge clk);
      gap++;
      if (speed !== last) begin
        n_checks++;
        if (gap != STEP_DIV) begin
          n_fail++;
          $display("FAIL ramp_gap: %0d cycles before 0x%02h required %0d", gap, speed, STEP_DIV);
        end
        gap = 0;
        last = speed;
      end
    end
    n_checks++;
    if (speed !== 8'h85 || at_target !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_reach: speed 0x%02h at %0b required 0x85/0", speed, at_target);
    end
    @(negedge clk);
    n_checks++;
    if (at_target !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_at_target: got %0b required 1", at_target);
    end else $display("ramp up reached 0x85, at_target set");
  endtask

  task automatic test_reversal;
    bit ok;
    int zc;
    target_speed = 8'h80;
    push_ramp(8'h85, 8'h80);
    wait_speed(8'h80, 20, ok);
    @(negedge clk);
    target_dir = 1'b1;
    target_speed = 8'h40;
    push_ramp(8'h80, 0);
    push_ramp(0, 8'h40);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || direction_control !== 1'b0) begin
      n_fail++;
      $display("FAIL rev_start: busy %0b dir %0b required 1/0", busy, direction_control);
    end
    wait_speed(8'h00, 60, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rev_to_zero: speed 0x%02h required 0x00", speed);
    end
    // One STOP_RAMP cycle observing zero, then DEAD_CYCLES in DEAD.
    zc = 1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (direction_control !== 1'b0) break;
      zc++;
    end
    n_checks++;
    if (zc != DEAD_CYCLES + 1 || direction_control !== 1'b1) begin
      n_fail++;
      $display("FAIL rev_dead: %0d zero cycles dir %0b required %0d/1", zc, direction_control, DEAD_CYCLES + 1);
    end else $display("reversal dead time %0d cycles", zc);
    wait_speed(8'h40, 40, ok);
    @(negedge clk);
    n_checks++;
    if (!ok || at_target !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rev_final: speed 0x%02h at %0b busy %0b required 0x40/1/0", speed, at_target, busy);
    end
  endtask

  task automatic test_abort;
    bit ok;
    target_dir = 1'b0;
    push_ramp(8'h40, 8'h30);
    wait_speed(8'h30, 20, ok);
    n_checks++;
    if (!ok || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ramp: speed 0x%02h busy %0b required 0x30/1", speed, busy);
    end
    target_dir = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_track: busy %0b required 0", busy);
    end
    push_ramp(8'h30, 8'h40);
    wait_speed(8'h40, 20, ok);
    n_checks++;
    if (!ok || direction_control !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_return: speed 0x%02h dir %0b required 0x40/1", speed, direction_control);
    end else $display("abort returned to 0x40 dir 1");
  endtask

  task automatic test_estop;
    bit ok;
    bit held_ok;
    int cnt;
    target_speed = 8'h80;
    push_ramp(8'h40, 8'h80);
    wait_speed(8'h80, 40, ok);
    // Single-cycle stop.
    @(negedge clk);
    stop = 1'b1;
    exp_q.push_back(8'h00);
    @(negedge clk);
    stop = 1'b0;
    n_checks++;
    if (speed !== 8'h00 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL estop_pulse: speed 0x%02h busy %0b required 0x00/1", speed, busy);
    end
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      cnt++;
      if (busy === 1'b0) break;
    end
    n_checks++;
    if (cnt != DEAD_CYCLES || direction_control !== 1'b1) begin
      n_fail++;
      $display("FAIL estop_dead: %0d cycles dir %0b required %0d/1", cnt, direction_control, DEAD_CYCLES);
    end else $display("estop pulse released after %0d cycles", cnt);
    push_ramp(0, 8'h80);
    wait_speed(8'h80, 60, ok);
    // Held stop: dead time counts only after release.
    @(negedge clk);
    stop = 1'b1;
    exp_q.push_back(8'h00);
    held_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (speed !== 8'h00 || busy !== 1'b1) held_ok = 1'b0;
    end
    stop = 1'b0;
    n_checks++;
    if (!held_ok) begin
      n_fail++;
      $display("FAIL estop_hold: speed 0x%02h busy %0b during hold required 0x00/1", speed, busy);
    end
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      cnt++;
      if (busy === 1'b0) break;
    end
    n_checks++;
    if (cnt != DEAD_CYCLES) begin
      n_fail++;
      $display("FAIL estop_hold_dead: %0d cycles required %0d", cnt, DEAD_CYCLES);
    end else $display("estop hold released after %0d cycles", cnt);
    push_ramp(0, 8'h80);
    wait_speed(8'h80, 60, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL estop_resume: speed 0x%02h required 0x80", speed);
    end
  endtask

  task automatic test_reset_mid_dead;
    bit ok;
    target_dir = 1'b0;
    target_speed = 8'h40;
    push_ramp(8'h80, 0);
    wait_speed(8'h00, 60, ok);
    for (int c = 0; c < 3; c++) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || direction_control !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_dead: busy %0b dir %0b required 1/1", busy, direction_control);
    end
    rst = 1'b1;
    target_speed = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (speed !== 8'h00 || direction_control !== 1'b0 || busy !== 1'b0 || at_target !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_dead_reset: speed 0x%02h dir %0b busy %0b at %0b required 0/0/0/0",
               speed, direction_control, busy, at_target);
    end else $display("reset in dead time cleared state");
    // Full reversal from standstill, then back with a ramp-down.
    target_dir = 1'b1;
    target_speed = 8'h20;
    push_ramp(0, 8'h20);
    wait_speed(8'h20, 60, ok);
    n_checks++;
    if (!ok || direction_control !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_rev1: speed 0x%02h dir %0b required 0x20/1", speed, direction_control);
    end
    target_dir = 1'b0;
    push_ramp(8'h20, 0);
    push_ramp(0, 8'h20);
    wait_speed(8'h00, 30, ok);
    wait_speed(8'h20, 60, ok);
    @(negedge clk);
    n_checks++;
    if (!ok || direction_control !== 1'b0 || at_target !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_rev2: speed 0x%02h dir %0b at %0b required 0x20/0/1",
               speed, direction_control, at_target);
    end else $display("second reversal complete");
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_abort();
    test_estop();
    test_reset_mid_dead();
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected steps left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound on simulation time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
